// File: rtl/afifo_wr_arb_pkg.sv
// Shared definitions for the async-FIFO write-side arbiter: FSM encoding,
// default parameters and the round-robin ready rule.
package afifo_wr_arb_pkg;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH   = 12;
    localparam int DEF_FLUSH_CYCLES = 8;

    // A requester may go when its rival is idle or the priority points at it;
    // its own valid is deliberately not part of the term.
    function automatic logic rr_ready(input logic other_valid, input logic prio, input logic idx);
        return (~other_valid) | (prio == idx);
    endfunction

endpackage

// File: rtl/afifo_wr_arb_rr_arb2.sv
// Two-way round-robin selector with its priority and last-grant registers.
module rr_arb2
    import afifo_wr_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic ready0_o,
    output logic ready1_o,
    output logic xfer_o,
    output logic sel_o,
    output logic grant_o
);

    logic prio_q;
    logic last_q;
    logic xfer0_s;
    logic xfer1_s;

    // Readies are exclusive whenever both requesters are valid.
    always_comb begin
        ready0_o = en_i & rr_ready(valid1_i, prio_q, 1'b0);
        ready1_o = en_i & rr_ready(valid0_i, prio_q, 1'b1);
        xfer0_s  = valid0_i & ready0_o;
        xfer1_s  = valid1_i & ready1_o;
        xfer_o   = xfer0_s | xfer1_s;
        sel_o    = xfer1_s;
        if (xfer_o) begin
            grant_o = sel_o;
        end else begin
            grant_o = last_q;
        end
    end

    // Priority flips away from whoever just transferred.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
            last_q <= 1'b0;
        end else if (xfer_o) begin
            prio_q <= ~sel_o;
            last_q <= sel_o;
        end else begin
            prio_q <= prio_q;
            last_q <= last_q;
        end
    end

endmodule

// File: rtl/afifo_wr_arb.sv
// Write-side arbiter for an async FIFO: two requesters share the write port,
// and a flush holds the FIFO in reset for a fixed number of cycles.
module afifo_wr_arb
    import afifo_wr_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  fifo_wr_en,
    input  logic                  fifo_full,
    output logic                  fifo_rst,
    output logic                  grant,
    output logic                  busy,
    output logic [15:0]           wr_count
);

    localparam logic [7:0] CNT_LOAD = 8'(FLUSH_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [15:0] wr_count_q;
    logic        eligible_s;
    logic        xfer_s;
    logic        sel_s;

    assign eligible_s = (state_q == ST_RUN) & ~fifo_full;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (eligible_s),
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .ready0_o (req0_ready),
        .ready1_o (req1_ready),
        .xfer_o   (xfer_s),
        .sel_o    (sel_s),
        .grant_o  (grant)
    );

    // Write port mux; data is forced to zero when nothing is written.
    always_comb begin
        fifo_wr_en = xfer_s;
        if (xfer_s) begin
            fifo_din = sel_s ? req1_data : req0_data;
        end else begin
            fifo_din = '0;
        end
    end

    assign fifo_rst = (state_q == ST_FLUSH);
    assign busy     = (state_q == ST_FLUSH);
    assign wr_count = wr_count_q;

    // Flush/run sequencing; a flush seen in RUN still lets that cycle's write land.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FLUSH;
            cnt_q      <= CNT_LOAD;
            wr_count_q <= 16'd0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (flush) begin
                        cnt_q <= CNT_LOAD;
                    end else if (cnt_q == 8'd0) begin
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_q    <= ST_FLUSH;
                        cnt_q      <= CNT_LOAD;
                        wr_count_q <= 16'd0;
                    end else if (xfer_s) begin
                        wr_count_q <= wr_count_q + 16'd1;
                    end else begin
                        wr_count_q <= wr_count_q;
                    end
                end
                default: begin
                    state_q    <= ST_FLUSH;
                    cnt_q      <= CNT_LOAD;
                    wr_count_q <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Directed bench for afifo_wr_arb: reset/flush timing, round-robin table, full stall, wrap.
module tb_afifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] req0_data, req1_data, fifo_din;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic        flush, fifo_wr_en, fifo_full, fifo_rst, grant, busy;
    logic [15:0] wr_count;

    int tests = 0;
    int failed = 0;
    int n;

    typedef struct {
        logic        v0, v1, full;
        logic [11:0] d0, d1;
        logic        r0, r1, we;
        logic [11:0] din;
        logic        g;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[11];

    afifo_wr_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .flush(flush), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .fifo_rst(fifo_rst), .grant(grant),
        .busy(busy), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Move to the next sample point (just after the falling edge).
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Counts consecutive cycles with fifo_rst high, starting with the current one.
    task automatic count_flush(input int reflush_at, output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!fifo_rst) break;
            cnt++;
            flush = (cnt == reflush_at);
            next_cycle();
        end
        flush = 1'b0;
    endtask

    task automatic chk_idle_flush(input string tag);
        chk({tag, "_fifo_rst"}, 32'(fifo_rst), 32'd1);
        chk({tag, "_busy"},     32'(busy),     32'd1);
        chk({tag, "_ready0"},   32'(req0_ready), 32'd0);
        chk({tag, "_ready1"},   32'(req1_ready), 32'd0);
        chk({tag, "_wr_en"},    32'(fifo_wr_en), 32'd0);
        chk({tag, "_din"},      32'(fifo_din),   32'd0);
        chk({tag, "_grant"},    32'(grant),      32'd0);
        chk({tag, "_wr_count"}, 32'(wr_count),   32'd0);
    endtask

    initial begin
        //        v0    v1    full  d0       d1       r0    r1    we    din      g     cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 16'd4};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 12'h111, 12'h000, 1'b1, 1'b0, 1'b1, 12'h111, 1'b0, 16'd4};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h222, 1'b0, 1'b1, 1'b1, 12'h222, 1'b1, 16'd5};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 12'h333, 12'h444, 1'b1, 1'b0, 1'b1, 12'h333, 1'b0, 16'd6};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 12'h555, 12'h666, 1'b0, 1'b1, 1'b1, 12'h666, 1'b1, 16'd7};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 12'h555, 12'h666, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 16'd8};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 12'h555, 12'h666, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 16'd8};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 12'h555, 12'h666, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 16'd8};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 12'h777, 12'h888, 1'b1, 1'b0, 1'b1, 12'h777, 1'b0, 16'd8};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 12'h999, 12'h000, 1'b1, 1'b1, 1'b1, 12'h999, 1'b0, 16'd9};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 16'd10};

        rst_n = 1'b0; flush = 1'b0; fifo_full = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 12'h000; req1_data = 12'h000;

        // Reset held for a few cycles
        repeat (3) @(negedge clk);
        #1;
        chk_idle_flush("reset");

        // Release: fifo_rst high for exactly 8 cycles
        rst_n = 1'b1;
        count_flush(0, n);
        chk("release_flush_len", 32'(n), 32'd8);
        chk("release_busy", 32'(busy), 32'd0);

        // Both valid from fresh reset: grants 0,1,0,1
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 12'hA00; req1_data = 12'hB00;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("alt_grant", 32'(grant), 32'(k % 2));
            chk("alt_wr_en", 32'(fifo_wr_en), 32'd1);
            chk("alt_din", 32'(fifo_din), (k % 2 == 0) ? 32'h0A00 : 32'h0B00);
            next_cycle();
        end

        // Table-driven vectors, continuing from prio=0, last grant=1, count=4
        for (int i = 0; i < 11; i++) begin
            req0_valid = vecs[i].v0; req1_valid = vecs[i].v1; fifo_full = vecs[i].full;
            req0_data = vecs[i].d0;  req1_data = vecs[i].d1;
            #1;
            chk($sformatf("v%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
            chk($sformatf("v%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
            chk($sformatf("v%0d_wr_en", i),  32'(fifo_wr_en), 32'(vecs[i].we));
            chk($sformatf("v%0d_din", i),    32'(fifo_din),   32'(vecs[i].din));
            chk($sformatf("v%0d_grant", i),  32'(grant),      32'(vecs[i].g));
            chk($sformatf("v%0d_count", i),  32'(wr_count),   32'(vecs[i].cnt));
            chk($sformatf("v%0d_busy", i),   32'(busy),       32'd0);
            next_cycle();
        end

        // Flush pulse coinciding with a req0 transfer of 0xABC
        req0_valid = 1'b1; req0_data = 12'hABC; flush = 1'b1;
        #1;
        chk("flushxfer_wr_en", 32'(fifo_wr_en), 32'd1);
        chk("flushxfer_din", 32'(fifo_din), 32'h0ABC);
        next_cycle();
        flush = 1'b0;
        #1;
        chk("flushxfer_count", 32'(wr_count), 32'd0);
        chk("flushxfer_ready0", 32'(req0_ready), 32'd0);
        chk("flushxfer_wr_en_off", 32'(fifo_wr_en), 32'd0);
        req0_valid = 1'b0;
        count_flush(0, n);
        chk("flushxfer_len", 32'(n), 32'd8);

        // Flush re-asserted in flush cycle 5
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        count_flush(5, n);
        chk("reflush_len", 32'(n), 32'd13);

        // Reset during RUN with a few words written
        req0_valid = 1'b1;
        repeat (3) next_cycle();
        chk("midrun_pre_count", 32'(wr_count), 32'd3);
        rst_n = 1'b0;
        next_cycle();
        chk_idle_flush("midrun_reset");
        rst_n = 1'b1;
        req0_valid = 1'b0;
        count_flush(0, n);
        chk("midrun_flush_len", 32'(n), 32'd8);

        // Counter wrap: 65535 writes then one more
        req0_valid = 1'b1; req0_data = 12'h055;
        repeat (65535) next_cycle();
        chk("wrap_ffff", 32'(wr_count), 32'h0000FFFF);
        next_cycle();
        chk("wrap_zero", 32'(wr_count), 32'h00000000);
        req0_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
